// File: rtl/mux_scan_controller_pkg.sv
// Shared types and constants for the 4:1 mux scan sequencer.
// The select code is {a,b}: a is the MSB of the channel index, b is the LSB.
package mux_scan_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   localparam int CH_W   = 2;
   localparam int NUM_CH = 4;

   localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

   // Channel index bit positions that drive the mux select lines.
   localparam int SEL_A_BIT = 1;
   localparam int SEL_B_BIT = 0;

   function automatic int cnt_width(input int dwell);
      return (dwell > 1) ? $clog2(dwell) : 1;
   endfunction

endpackage

// File: rtl/mux_scan_controller_if.sv
// Handshake and data bundle between the scan sequencer and its environment.
// The master side drives the requests and the mux output; the slave side is the sequencer.
interface mux_scan_controller_if;
   import mux_scan_pkg::*;

   logic              start;
   logic              continuous;
   logic              abort;
   logic              q;
   logic              a;
   logic              b;
   logic              busy;
   logic              sample_valid;
   logic [CH_W-1:0]   sample_ch;
   logic              sample_bit;
   logic [NUM_CH-1:0] frame;
   logic              frame_valid;

   modport master (
      output start, continuous, abort, q,
      input  a, b, busy, sample_valid, sample_ch, sample_bit, frame, frame_valid
   );

   modport slave (
      input  start, continuous, abort, q,
      output a, b, busy, sample_valid, sample_ch, sample_bit, frame, frame_valid
   );

endinterface

// File: rtl/mux_scan_controller_dwell_counter.sv
// Counts the cycles a select code has been held.
// last is high on the final dwell cycle; the count then wraps to zero.
module dwell_counter
   import mux_scan_pkg::*;
#(
   parameter int DWELL = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic en,
   output logic last
);

   localparam int              CNT_W    = cnt_width(DWELL);
   localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(DWELL - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (en) begin
         if (last) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   assign last = (cnt == LAST_VAL);

endmodule

// File: rtl/mux_scan_controller.sv
// Steps the 4:1 mux select through channels 0..3, samples q on the last dwell cycle
// of each channel and publishes a 4-bit frame once channel 3 has been sampled.
module mux_scan_controller
   import mux_scan_pkg::*;
#(
   parameter int DWELL = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   mux_scan_controller_if.slave bus
);

   state_t            state;
   state_t            state_next;
   logic [CH_W-1:0]   ch;
   logic [CH_W-1:0]   ch_next;
   logic              cont_r;
   logic              cont_next;
   logic [NUM_CH-1:0] shadow;
   logic              capture;
   logic              frame_load;
   logic              cnt_clear;
   logic              cnt_en;
   logic              last;

   logic              sample_valid;
   logic [CH_W-1:0]   sample_ch;
   logic              sample_bit;
   logic [NUM_CH-1:0] frame;
   logic              frame_valid;

   dwell_counter #(
      .DWELL(DWELL)
   ) u_dwell (
      .clk   (clk),
      .rst   (rst),
      .clear (cnt_clear),
      .en    (cnt_en),
      .last  (last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Abort outranks everything in SCAN, including the channel-3 sample edge.
   always_comb begin
      state_next = state;
      ch_next    = ch;
      cont_next  = cont_r;
      capture    = 1'b0;
      frame_load = 1'b0;
      cnt_clear  = 1'b0;
      cnt_en     = 1'b0;
      case (state)
         IDLE: begin
            cnt_clear = 1'b1;
            ch_next   = '0;
            if (bus.start && !bus.abort) begin
               state_next = SCAN;
               cont_next  = bus.continuous;
            end
         end
         SCAN: begin
            if (bus.abort) begin
               state_next = IDLE;
               ch_next    = '0;
               cnt_clear  = 1'b1;
            end else begin
               cnt_en = 1'b1;
               if (last) begin
                  capture = 1'b1;
                  if (ch == LAST_CH) begin
                     frame_load = 1'b1;
                     ch_next    = '0;
                     if (!cont_r) begin
                        state_next = IDLE;
                     end
                  end else begin
                     ch_next = ch + CH_W'(1);
                  end
               end
            end
         end
         default: begin
            state_next = IDLE;
            ch_next    = '0;
         end
      endcase
   end

   // The channel-3 bit goes straight from q into frame, so shadow[3] is never read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ch           <= '0;
         cont_r       <= 1'b0;
         shadow       <= '0;
         sample_valid <= 1'b0;
         sample_ch    <= '0;
         sample_bit   <= 1'b0;
         frame        <= '0;
         frame_valid  <= 1'b0;
      end else begin
         ch           <= ch_next;
         cont_r       <= cont_next;
         sample_valid <= capture;
         frame_valid  <= frame_load;
         if (capture) begin
            sample_ch  <= ch;
            sample_bit <= bus.q;
            shadow[ch] <= bus.q;
         end
         if (frame_load) begin
            frame <= {bus.q, shadow[NUM_CH-2:0]};
         end
      end
   end

   assign bus.a            = ch[SEL_A_BIT];
   assign bus.b            = ch[SEL_B_BIT];
   assign bus.busy         = (state == SCAN);
   assign bus.sample_valid = sample_valid;
   assign bus.sample_ch    = sample_ch;
   assign bus.sample_bit   = sample_bit;
   assign bus.frame        = frame;
   assign bus.frame_valid  = frame_valid;

endmodule

// File: tb/tb_mux_scan_controller.sv
// Self-checking bench: three sequencers (DWELL 4, 2, 1) share stimulus and a combinational
// mux model; a timeline model predicts every output each cycle, plus literal pin checks.
module tb_mux_scan_controller;
   import mux_scan_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       continuous;
   logic       abort;
   logic [3:0] data;

   logic [2:0] a_o;
   logic [2:0] b_o;
   logic [2:0] busy_o;
   logic [2:0] sv_o;
   logic [2:0] sb_o;
   logic [2:0] fv_o;
   logic [1:0] sch_o   [3];
   logic [3:0] frame_o [3];

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      localparam int D = (gi == 0) ? 4 : ((gi == 1) ? 2 : 1);

      mux_scan_controller_if bus ();

      assign bus.start      = start;
      assign bus.continuous = continuous;
      assign bus.abort      = abort;
      assign bus.q          = data[{bus.a, bus.b}];

      mux_scan_controller #(
         .DWELL(D)
      ) dut (
         .clk (clk),
         .rst (rst),
         .bus (bus)
      );

      assign a_o[gi]     = bus.a;
      assign b_o[gi]     = bus.b;
      assign busy_o[gi]  = bus.busy;
      assign sv_o[gi]    = bus.sample_valid;
      assign sb_o[gi]    = bus.sample_bit;
      assign fv_o[gi]    = bus.frame_valid;
      assign sch_o[gi]   = bus.sample_ch;
      assign frame_o[gi] = bus.frame;
   end

   // Model: m_e counts edges since the scan began; samples fall on multiples of the dwell.
   bit         m_busy   [3];
   bit         m_cont   [3];
   int         m_e      [3];
   logic [3:0] m_shadow [3];
   logic [3:0] m_frame  [3];
   logic [1:0] m_sel    [3];
   logic [1:0] m_sch    [3];
   logic       m_sv     [3];
   logic       m_sbit   [3];
   logic       m_fv     [3];

   function automatic int dwell_of(input int i);
      return (i == 0) ? 4 : ((i == 1) ? 2 : 1);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_busy[i]   = 1'b0;
         m_cont[i]   = 1'b0;
         m_e[i]      = 0;
         m_shadow[i] = 4'b0000;
         m_frame[i]  = 4'b0000;
         m_sel[i]    = 2'b00;
         m_sch[i]    = 2'b00;
         m_sv[i]     = 1'b0;
         m_sbit[i]   = 1'b0;
         m_fv[i]     = 1'b0;
      end
   endtask

   task automatic model_advance();
      int d;
      int chn;
      for (int i = 0; i < 3; i++) begin
         d       = dwell_of(i);
         m_sv[i] = 1'b0;
         m_fv[i] = 1'b0;
         if (!m_busy[i]) begin
            if (start && !abort) begin
               m_busy[i] = 1'b1;
               m_e[i]    = 0;
               m_cont[i] = continuous;
            end
         end else if (abort) begin
            m_busy[i] = 1'b0;
         end else begin
            m_e[i] = m_e[i] + 1;
            if (m_e[i] % d == 0) begin
               chn            = (m_e[i] / d - 1) % 4;
               m_sv[i]        = 1'b1;
               m_sch[i]       = 2'(chn);
               m_sbit[i]      = data[chn];
               m_shadow[i][chn] = data[chn];
               if (chn == 3) begin
                  m_frame[i] = m_shadow[i];
                  m_fv[i]    = 1'b1;
                  if (m_cont[i]) begin
                     m_e[i] = 0;
                  end else begin
                     m_busy[i] = 1'b0;
                  end
               end
            end
         end
         m_sel[i] = m_busy[i] ? 2'((m_e[i] / d) % 4) : 2'b00;
      end
   endtask

   task automatic check_val(input string name, input int idx,
                            input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s[%0d] at %0t: got %0h, expected %0h", name, idx, $time, act, exp);
      end
   endtask

   task automatic check_output();
      if (rst) model_reset();
      for (int i = 0; i < 3; i++) begin
         check_val("a",            i, a_o[i],     m_sel[i][1]);
         check_val("b",            i, b_o[i],     m_sel[i][0]);
         check_val("busy",         i, busy_o[i],  m_busy[i]);
         check_val("sample_valid", i, sv_o[i],    m_sv[i]);
         check_val("sample_ch",    i, sch_o[i],   m_sch[i]);
         check_val("sample_bit",   i, sb_o[i],    m_sbit[i]);
         check_val("frame",        i, frame_o[i], m_frame[i]);
         check_val("frame_valid",  i, fv_o[i],    m_fv[i]);
      end
   endtask

   // Inputs set here are sampled at the next rising edge; outputs are checked mid-cycle.
   task automatic apply_stimulus(input logic st, input logic co, input logic ab,
                                 input logic r, input logic [3:0] d);
      @(posedge clk);
      #1;
      start      = st;
      continuous = co;
      abort      = ab;
      rst        = r;
      data       = d;
      @(negedge clk);
      check_output();
      if (!rst) model_advance();
   endtask

   task automatic idle(input int n, input logic [3:0] d);
      for (int j = 0; j < n; j++) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, d);
   endtask

   initial begin
      logic st;
      logic co;
      logic ab;
      logic r;
      logic [3:0] d;

      start      = 1'b0;
      continuous = 1'b0;
      abort      = 1'b0;
      data       = 4'b0000;
      rst        = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_output();
      check_val("pin_rst_busy",  0, busy_o,     3'b000);
      check_val("pin_rst_frame", 0, frame_o[0], 4'b0000);
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
      idle(2, 4'b0000);

      // Single shot, A=1 B=0 C=1 D=1; call j observes the state after edge k+j-1.
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'b1101);
      for (int j = 1; j <= 17; j++) begin
         apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'b1101);
         if (j == 2) check_val("pin_busy_k",    0, busy_o[0], 1'b1);
         if (j == 5) begin
            check_val("pin_sv4_ch0",   0, sv_o[0],    1'b1);
            check_val("pin_sb4_ch0",   0, sb_o[0],    1'b1);
            check_val("pin_fv1",       2, fv_o[2],    1'b1);
            check_val("pin_frame1",    2, frame_o[2], 4'b1101);
         end
         if (j == 7) check_val("pin_sel4_k6",   0, {a_o[0], b_o[0]}, 2'b01);
         if (j == 9) begin
            check_val("pin_sb4_ch1",   0, sb_o[0],    1'b0);
            check_val("pin_fv2",       1, fv_o[1],    1'b1);
            check_val("pin_frame2",    1, frame_o[1], 4'b1101);
         end
         if (j == 17) begin
            check_val("pin_fv4",       0, fv_o[0],    1'b1);
            check_val("pin_frame4",    0, frame_o[0], 4'b1101);
            check_val("pin_busy4_end", 0, busy_o[0],  1'b0);
            check_val("pin_sch4_ch3",  0, sch_o[0],   2'b11);
         end
      end
      idle(3, 4'b1101);

      // Continuous: data becomes A=0 B=1 C=0 D=0 once the first DWELL=2 frame is taken.
      apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'b1101);
      for (int j = 1; j <= 17; j++) begin
         d = (j >= 9) ? 4'b0010 : 4'b1101;
         apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, d);
         if (j == 9) begin
            check_val("pin_cfv2_a",    1, fv_o[1],    1'b1);
            check_val("pin_cframe2_a", 1, frame_o[1], 4'b1101);
         end
         if (j == 13) check_val("pin_cframe2_hold", 1, frame_o[1], 4'b1101);
         if (j == 17) begin
            check_val("pin_cfv2_b",    1, fv_o[1],    1'b1);
            check_val("pin_cframe2_b", 1, frame_o[1], 4'b0010);
            check_val("pin_cframe4",   0, frame_o[0], 4'b0001);
         end
      end
      apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'b0010);
      idle(3, 4'b0010);

      // Abort while DWELL=4 is at count 1 of channel 2.
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'b1111);
      for (int j = 1; j <= 11; j++) begin
         apply_stimulus(1'b0, 1'b0, (j == 10), 1'b0, 4'b1111);
      end
      check_val("pin_abort_busy",  0, busy_o[0],        1'b0);
      check_val("pin_abort_sel",   0, {a_o[0], b_o[0]}, 2'b00);
      check_val("pin_abort_frame", 0, frame_o[0],       4'b0001);
      idle(8, 4'b1111);

      // Abort coinciding with the channel-3 sample edge.
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'b0110);
      for (int j = 1; j <= 17; j++) begin
         apply_stimulus(1'b0, 1'b0, (j == 16), 1'b0, 4'b0110);
      end
      check_val("pin_abort3_sv",    0, sv_o[0],    1'b0);
      check_val("pin_abort3_fv",    0, fv_o[0],    1'b0);
      check_val("pin_abort3_frame", 0, frame_o[0], 4'b0001);
      idle(4, 4'b0110);

      // A start pulse mid-scan must not disturb frame timing.
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'b1010);
      for (int j = 1; j <= 17; j++) begin
         apply_stimulus((j == 6), 1'b0, 1'b0, 1'b0, 4'b1010);
         if (j == 16) check_val("pin_restart_fv_early", 0, fv_o[0], 1'b0);
      end
      check_val("pin_restart_fv",    0, fv_o[0],    1'b1);
      check_val("pin_restart_frame", 0, frame_o[0], 4'b1010);
      idle(6, 4'b1010);

      // Reset after six cycles of SCAN.
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'b1101);
      for (int j = 1; j <= 8; j++) begin
         apply_stimulus(1'b0, 1'b0, 1'b0, (j == 7), 4'b1101);
         if (j == 6) check_val("pin_prereset_b", 0, b_o[0], 1'b1);
         if (j == 7) begin
            check_val("pin_reset_b",     0, b_o[0],     1'b0);
            check_val("pin_reset_busy",  0, busy_o[0],  1'b0);
            check_val("pin_reset_frame", 0, frame_o[0], 4'b0000);
         end
      end
      idle(20, 4'b1101);

      // Randomized traffic.
      d = 4'b0000;
      for (int n = 0; n < 3000; n++) begin
         st = ($urandom_range(0, 7) == 0);
         co = 1'($urandom_range(0, 1));
         ab = ($urandom_range(0, 39) == 0);
         r  = ($urandom_range(0, 599) == 0);
         if ($urandom_range(0, 5) == 0) d = 4'($urandom);
         apply_stimulus(st, co, ab, r, d);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
